// File: rtl/rat_pkg.sv
// rtl/rat_pkg.sv - shared op encoding and width helpers for the register alias table
package rat_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_SWAP     = 2'd1,
    OP_ROTATE   = 2'd2,
    OP_IDENTITY = 2'd3
  } rat_op_e;

  localparam int DEFAULT_NUM_REGS   = 4;
  localparam int DEFAULT_CKPT_DEPTH = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rat_ckpt_stack.sv
// rtl/rat_ckpt_stack.sv - LIFO of map snapshots with overflow/underflow flags
module rat_ckpt_stack
  import rat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_CKPT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      pop_ok,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      err_ovf,
  output logic                      err_unf
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic [CW-1:0]    count_m1;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // Simultaneous push and pop is treated as a protocol error: neither is honoured.
  assign push_ok  = push & ~pop & ~full;
  assign pop_ok   = pop & ~push & ~empty;
  assign count_m1 = count - CW'(1);
  assign wr_ptr   = AW'(count);
  assign rd_ptr   = AW'(count_m1);
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push_ok)     count <= count + CW'(1);
      else if (pop_ok) count <= count_m1;
      err_ovf <= err_ovf | (push & ~pop & full);
      err_unf <= err_unf | (pop & ~push & empty) | (push & pop);
    end
  end

endmodule

// File: rtl/register_alias_table.sv
// rtl/register_alias_table.sv - architectural-to-physical register permutation with checkpoint stack
module register_alias_table
  import rat_pkg::*;
#(
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int IDX_W      = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int CKPT_DEPTH = DEFAULT_CKPT_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_RD*IDX_W-1:0]         rd_idx,
  output logic [NUM_RD*IDX_W-1:0]         rd_map,
  input  logic                            op_valid,
  input  logic [1:0]                      op_code,
  input  logic [IDX_W-1:0]                op_a,
  input  logic [IDX_W-1:0]                op_b,
  input  logic                            ckpt_push,
  input  logic                            ckpt_pop,
  output logic [$clog2(CKPT_DEPTH+1)-1:0] ckpt_count,
  output logic                            ckpt_full,
  output logic                            ckpt_empty,
  output logic                            op_drop,
  output logic                            err_ovf,
  output logic                            err_unf
);

  localparam int MAP_W = NUM_REGS * IDX_W;

  logic [NUM_REGS-1:0][IDX_W-1:0] map_q;
  logic [NUM_REGS-1:0][IDX_W-1:0] op_map;
  logic [NUM_REGS-1:0][IDX_W-1:0] map_d;
  logic [MAP_W-1:0]               snap;
  logic                           restore;

  rat_ckpt_stack #(
    .WIDTH (MAP_W),
    .DEPTH (CKPT_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (ckpt_push),
    .pop     (ckpt_pop),
    .din     (map_q),
    .dout    (snap),
    .pop_ok  (restore),
    .count   (ckpt_count),
    .full    (ckpt_full),
    .empty   (ckpt_empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  // Each op is a permutation of a permutation, so the map can never gain a duplicate.
  always_comb begin
    op_map = map_q;
    case (rat_op_e'(op_code))
      OP_SWAP: begin
        op_map[op_a] = map_q[op_b];
        op_map[op_b] = map_q[op_a];
      end
      OP_ROTATE: begin
        for (int i = 0; i < NUM_REGS; i++) op_map[i] = map_q[(i + 1) % NUM_REGS];
      end
      OP_IDENTITY: begin
        for (int i = 0; i < NUM_REGS; i++) op_map[i] = IDX_W'(i);
      end
      default: op_map = map_q;
    endcase
  end

  always_comb begin
    map_d = map_q;
    if (restore)       map_d = snap;
    else if (op_valid) map_d = op_map;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) map_q[i] <= IDX_W'(i);
      op_drop <= 1'b0;
    end else begin
      map_q   <= map_d;
      op_drop <= restore & op_valid;
    end
  end

  always_comb begin
    rd_map = '0;
    for (int p = 0; p < NUM_RD; p++)
      rd_map[p*IDX_W +: IDX_W] = map_q[rd_idx[p*IDX_W +: IDX_W]];
  end

endmodule

// File: tb/tb_register_alias_table.sv
// tb/tb_register_alias_table.sv - directed self-checking bench for register_alias_table
module tb_register_alias_table;
  import rat_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rd_idx;
  logic [3:0] rd_map;
  logic       op_valid;
  logic [1:0] op_code;
  logic [1:0] op_a, op_b;
  logic       ckpt_push, ckpt_pop;
  logic [1:0] ckpt_count;
  logic       ckpt_full, ckpt_empty, op_drop, err_ovf, err_unf;

  int checks = 0;
  int errors = 0;

  register_alias_table #(
    .NUM_REGS   (4),
    .NUM_RD     (2),
    .CKPT_DEPTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (rd_idx),
    .rd_map     (rd_map),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .ckpt_push  (ckpt_push),
    .ckpt_pop   (ckpt_pop),
    .ckpt_count (ckpt_count),
    .ckpt_full  (ckpt_full),
    .ckpt_empty (ckpt_empty),
    .op_drop    (op_drop),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // exp packs {map[3],map[2],map[1],map[0]}, two bits each
  task automatic check_map(input string tag, input logic [7:0] exp);
    rd_idx = {2'd1, 2'd0}; #1;
    check({tag, "_lo"}, rd_map, exp[3:0]);
    rd_idx = {2'd3, 2'd2}; #1;
    check({tag, "_hi"}, rd_map, exp[7:4]);
  endtask

  task automatic check_stack(input string tag, input int cnt, input logic ovf, input logic unf);
    check({tag, "_count"}, ckpt_count, cnt);
    check({tag, "_empty"}, ckpt_empty, cnt == 0);
    check({tag, "_full"}, ckpt_full, cnt == 2);
    check({tag, "_ovf"}, err_ovf, ovf);
    check({tag, "_unf"}, err_unf, unf);
  endtask

  task automatic cycle(input logic v, input logic [1:0] c, input logic [1:0] a,
                       input logic [1:0] b, input logic pu, input logic po);
    op_valid = v; op_code = c; op_a = a; op_b = b; ckpt_push = pu; ckpt_pop = po;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 2'd0; op_a = 2'd0; op_b = 2'd0; ckpt_push = 1'b0; ckpt_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd_idx = 4'd0;
    op_valid = 1'b0; op_code = 2'd0; op_a = 2'd0; op_b = 2'd0; ckpt_push = 1'b0; ckpt_pop = 1'b0;
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, OP_NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;

    check_map("reset_map", 8'he4);
    check_stack("reset", 0, 1'b0, 1'b0);
    check("reset_drop", op_drop, 0);

    // SWAP 1,3 not visible until the next cycle
    op_valid = 1'b1; op_code = OP_SWAP; op_a = 2'd1; op_b = 2'd3;
    rd_idx = {2'd3, 2'd1}; #1;
    check("swap_nobypass", rd_map, {2'd3, 2'd1});
    cycle(1'b1, OP_SWAP, 2'd1, 2'd3, 1'b0, 1'b0);
    rd_idx = {2'd3, 2'd1}; #1;
    check("swap13_read", rd_map, {2'd1, 2'd3});
    check_map("swap13", 8'h6c);
    cycle(1'b1, OP_SWAP, 2'd2, 2'd2, 1'b0, 1'b0);
    check_map("swap22", 8'h6c);

    cycle(1'b1, OP_IDENTITY, 2'd0, 2'd0, 1'b0, 1'b0);
    check_map("ident1", 8'he4);
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b0, 1'b0);
    check_map("rot1", 8'h39);
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b0, 1'b0);
    check_map("rot2", 8'h4e);
    cycle(1'b1, OP_IDENTITY, 2'd0, 2'd0, 1'b0, 1'b0);
    check_map("ident2", 8'he4);

    // push with same-cycle op, then pop discards its op
    cycle(1'b1, OP_SWAP, 2'd0, 2'd1, 1'b1, 1'b0);
    check_map("push_swap01", 8'he1);
    check_stack("push1", 1, 1'b0, 1'b0);
    cycle(1'b1, OP_SWAP, 2'd2, 2'd3, 1'b0, 1'b0);
    check_map("swap23", 8'hb1);
    cycle(1'b1, OP_SWAP, 2'd0, 2'd3, 1'b0, 1'b1);
    check_map("pop_restore", 8'he4);
    check("pop_drop", op_drop, 1);
    check_stack("pop1", 0, 1'b0, 1'b0);
    cycle(1'b0, OP_NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    check("drop_pulse_end", op_drop, 0);

    // fill, overflow, drain, underflow
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b1, 1'b0);
    check_stack("fill1", 1, 1'b0, 1'b0);
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b1, 1'b0);
    check_stack("fill2", 2, 1'b0, 1'b0);
    check_map("fill2", 8'h4e);
    cycle(1'b1, OP_SWAP, 2'd0, 2'd1, 1'b1, 1'b0);
    check_stack("ovf", 2, 1'b1, 1'b0);
    check_map("ovf_op_applies", 8'h4b);
    cycle(1'b0, OP_NOP, 2'd0, 2'd0, 1'b0, 1'b1);
    check_map("lifo_top", 8'h39);
    check_stack("drain1", 1, 1'b1, 1'b0);
    cycle(1'b0, OP_NOP, 2'd0, 2'd0, 1'b0, 1'b1);
    check_map("lifo_bottom", 8'he4);
    check_stack("drain2", 0, 1'b1, 1'b0);
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b0, 1'b1);
    check_stack("unf", 0, 1'b1, 1'b1);
    check_map("unf_op_applies", 8'h39);
    check("unf_no_drop", op_drop, 0);

    // reset mid-op discards everything and clears sticky errors
    reset = 1'b0;
    cycle(1'b1, OP_ROTATE, 2'd0, 2'd0, 1'b1, 1'b0);
    reset = 1'b1;
    check_map("rst_mid", 8'he4);
    check_stack("rst_mid", 0, 1'b0, 1'b0);

    // push and pop together: both ignored, op applies
    cycle(1'b1, OP_SWAP, 2'd0, 2'd1, 1'b1, 1'b1);
    check_stack("pushpop", 0, 1'b0, 1'b1);
    check_map("pushpop_op", 8'he1);
    check("pushpop_drop", op_drop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
